// File: rtl/sar_adc_pkg.sv
// Shared types, default parameters and latency helper for the SAR ADC controller.
package sar_adc_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SAMPLE = 3'd1,
      S_SETTLE = 3'd2,
      S_DECIDE = 3'd3,
      S_DONE   = 3'd4
   } sar_state_t;

   localparam int SAR_WIDTH_DEF  = 8;
   localparam int SAR_SAMPLE_DEF = 4;
   localparam int SAR_SETTLE_DEF = 3;
   localparam int SAR_SYNC_DEF   = 2;

   // Edge index (counted from the start edge) after which done is high.
   function automatic int sar_latency(input int width, input int sample, input int settle);
      return sample + width * (settle + 1);
   endfunction

endpackage

// File: rtl/sar_adc_ctrl_sync.sv
// Reset-to-0 multi-flop synchronizer bringing the async comparator output into clk.
module sar_cmp_sync
   import sar_adc_pkg::*;
#(
   parameter int SYNC_STAGES = SAR_SYNC_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic cmp_in,
   output logic cmp_s
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;

   genvar gi;
   generate
      for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
         if (gi == 0) begin : g_first
            assign sync_d[gi] = cmp_in;
         end else begin : g_rest
            assign sync_d[gi] = sync_q[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign cmp_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller: sample, then one settle+decide slot per bit.
// Optional build macro SAR_ADC_CTRL_CONTINUOUS_EN adds a 'continuous' input for back-to-back conversions.
module sar_adc_ctrl
   import sar_adc_pkg::*;
#(
   parameter int WIDTH         = SAR_WIDTH_DEF,
   parameter int SAMPLE_CYCLES = SAR_SAMPLE_DEF,
   parameter int SETTLE_CYCLES = SAR_SETTLE_DEF,
   parameter int SYNC_STAGES   = SAR_SYNC_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
`ifdef SAR_ADC_CTRL_CONTINUOUS_EN
   input  logic             continuous,
`endif
   input  logic             cmp_in,
   output logic             sample,
   output logic [WIDTH-1:0] dac_code,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             result_valid
);

   localparam logic [2:0] ST_IDLE   = 3'(S_IDLE);
   localparam logic [2:0] ST_SAMPLE = 3'(S_SAMPLE);
   localparam logic [2:0] ST_SETTLE = 3'(S_SETTLE);
   localparam logic [2:0] ST_DECIDE = 3'(S_DECIDE);
   localparam logic [2:0] ST_DONE   = 3'(S_DONE);

   localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int IDX_W   = $clog2(WIDTH);

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [WIDTH-1:0] code_q, code_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             valid_q, valid_d;
   logic             cmp_s;

   sar_cmp_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst   (rst),
      .cmp_in(cmp_in),
      .cmp_s (cmp_s)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      code_d   = code_q;
      result_d = result_q;
      valid_d  = valid_q;
      case (state_q)
         ST_IDLE: begin
            code_d = '0;
            if (start) begin
               state_d = ST_SAMPLE;
               cnt_d   = CNT_W'(SAMPLE_CYCLES - 1);
            end
         end
         ST_SAMPLE: begin
            if (cnt_q == '0) begin
               state_d = ST_SETTLE;
               cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
               idx_d   = IDX_W'(WIDTH - 1);
               code_d  = '0;
               code_d[WIDTH-1] = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_SETTLE: begin
            if (cnt_q == '0) begin
               state_d = ST_DECIDE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_DECIDE: begin
            // Comparator low means the trial overshot the input: drop this bit.
            if (!cmp_s) begin
               code_d[idx_q] = 1'b0;
            end
            if (idx_q != '0) begin
               code_d[idx_q - 1'b1] = 1'b1;
               idx_d   = idx_q - 1'b1;
               cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
               state_d = ST_SETTLE;
            end else begin
               result_d = code_d;
               valid_d  = 1'b1;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            code_d  = '0;
            state_d = ST_IDLE;
`ifdef SAR_ADC_CTRL_CONTINUOUS_EN
            if (continuous) begin
               state_d = ST_SAMPLE;
               cnt_d   = CNT_W'(SAMPLE_CYCLES - 1);
            end
`endif
         end
         default: begin
            state_d = ST_IDLE;
            code_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         idx_q    <= IDX_W'(WIDTH - 1);
         code_q   <= '0;
         result_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         code_q   <= code_d;
         result_q <= result_d;
         valid_q  <= valid_d;
      end
   end

   assign sample       = (state_q == ST_SAMPLE);
   assign busy         = (state_q != ST_IDLE);
   assign done         = (state_q == ST_DONE);
   assign dac_code     = code_q;
   assign result       = result_q;
   assign result_valid = valid_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Scoreboard bench for sar_adc_ctrl driving an ideal comparator model cmp_in = (V >= dac_code).
module tb_sar_adc_ctrl;

   localparam int LAT = 36;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       cmp_in;
   logic       sample;
   logic [7:0] dac_code;
   logic       busy;
   logic       done;
   logic [7:0] result;
   logic       result_valid;
`ifdef SAR_ADC_CTRL_CONTINUOUS_EN
   logic       continuous;
`endif

   logic [7:0] vval;
   assign cmp_in = (vval >= dac_code);

   sar_adc_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
`ifdef SAR_ADC_CTRL_CONTINUOUS_EN
      .continuous  (continuous),
`endif
      .cmp_in      (cmp_in),
      .sample      (sample),
      .dac_code    (dac_code),
      .busy        (busy),
      .done        (done),
      .result      (result),
      .result_valid(result_valid)
   );

   always #5 clk = ~clk;

   int edge_cnt = 0;
   always @(posedge clk) edge_cnt++;

   typedef struct {
      logic [7:0] res;
      int         edge_no;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, want, edge_cnt);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (exp_q.size() == 0) begin
            check("spurious_done", done, 1'b0);
         end else begin
            mon_e = exp_q.pop_front();
            $display("done: result=%02h expected=%02h edge=%0d expected_edge=%0d",
                     result, mon_e.res, edge_cnt, mon_e.edge_no);
            check("result", result, mon_e.res);
            check("done_edge", edge_cnt, mon_e.edge_no);
            check("result_valid", result_valid, 1'b1);
         end
      end
   end

   task automatic kick(input logic [7:0] v, output int e0);
      @(negedge clk);
      vval  = v;
      start = 1'b1;
      e0    = edge_cnt + 1;
      exp_q.push_back('{v, e0 + LAT});
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_edge(input int e);
      while (edge_cnt < e) @(negedge clk);
   endtask

   task automatic drain();
      int k;
      for (k = 0; k < 3000 && (exp_q.size() != 0 || busy); k++) @(negedge clk);
      check("drain_pending", exp_q.size(), 0);
      check("drain_idle", busy, 1'b0);
   endtask

   logic [7:0] trials [8] = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
   logic [7:0] vecs   [3] = '{8'h00, 8'hFF, 8'h80};

   initial begin
      int e0;
      int lows;
      rst   = 1'b1;
      start = 1'b0;
      vval  = 8'h00;
`ifdef SAR_ADC_CTRL_CONTINUOUS_EN
      continuous = 1'b0;
`endif
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_sample", sample, 1'b0);
      check("rst_dac", dac_code, 8'h00);
      check("rst_result", result, 8'h00);
      check("rst_valid", result_valid, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // V=0xA5 with trial-code sequence
      kick(8'hA5, e0);
      check("sample_hi", sample, 1'b1);
      check("valid_before", result_valid, 1'b0);
      for (int k = 0; k < 8; k++) begin
         wait_edge(e0 + 4 + 4 * k);
         check("trial_code", dac_code, trials[k]);
         check("trial_sample", sample, 1'b0);
      end
      drain();

      // boundary inputs
      for (int i = 0; i < 3; i++) begin
         kick(vecs[i], e0);
         drain();
      end

      // start held high: one conversion every 38 edges with a single idle cycle between
      @(negedge clk);
      vval  = 8'h3C;
      start = 1'b1;
      e0    = edge_cnt + 1;
      for (int k = 0; k < 6; k++) exp_q.push_back('{8'h3C, e0 + 38 * k + LAT});
      lows = 0;
      while (edge_cnt < e0 + 199) begin
         @(negedge clk);
         if (!busy) lows++;
      end
      start = 1'b0;
      check("idle_gaps", lows, 5);
      drain();

      // second start mid-conversion is ignored
      kick(8'h5B, e0);
      wait_edge(e0 + 9);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lows = 0;
      while (edge_cnt < e0 + LAT) begin
         @(negedge clk);
         if (!busy) lows++;
      end
      check("busy_gap_restart", lows, 0);
      drain();

      // async reset mid-conversion discards everything
      kick(8'h77, e0);
      wait_edge(e0 + 19);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      exp_q.delete();
      check("arst_busy", busy, 1'b0);
      check("arst_sample", sample, 1'b0);
      check("arst_dac", dac_code, 8'h00);
      check("arst_done", done, 1'b0);
      check("arst_result", result, 8'h00);
      check("arst_valid", result_valid, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      kick(8'h11, e0);
      drain();

`ifdef SAR_ADC_CTRL_CONTINUOUS_EN
      continuous = 1'b1;
      kick(8'h5A, e0);
      exp_q.push_back('{8'h5A, e0 + 37 + LAT});
      exp_q.push_back('{8'h5A, e0 + 74 + LAT});
      lows = 0;
      while (edge_cnt < e0 + 110) begin
         @(negedge clk);
         if (edge_cnt == e0 + 80) continuous = 1'b0;
         if (!busy) lows++;
      end
      check("cont_busy_gap", lows, 0);
      drain();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
